music_note_sequencer: RTL and testbench



---
 rtl/music_note_sequencer.sv | 178 +++++++++++++++++
 tb/tb_music_note_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/music_note_sequencer.sv
// Fixed-melody note sequencer: steps a 16-entry {freq, beats} table and drives a
// 14-bit frequency word, with a silent gap after each note and optional looping.
module music_note_sequencer #(
  parameter int unsigned TICKS_PER_BEAT = 4000,
  parameter int unsigned GAP_TICKS      = 320
) (
  input  logic        CLK_32KHz,
  input  logic        reset_n,
  input  logic        play,
  input  logic        stop,
  input  logic        loop_enable,
  output logic [13:0] outputFrequency,
  output logic        noteActive,
  output logic [3:0]  noteIndex,
  output logic        busy,
  output logic        songDone
);

  localparam int unsigned FREQ_W  = 14;
  localparam int unsigned BEAT_W  = 4;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned ENTRY_W = FREQ_W + BEAT_W;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_BEAT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
  localparam logic             HAS_GAP   = (GAP_TICKS != 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_NOTE  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  // Melody ROM; beats == 0 is the end-of-song marker.
  function automatic logic [ENTRY_W-1:0] note_entry(input logic [IDX_W-1:0] idx);
    logic [ENTRY_W-1:0] e;
    case (idx)
      4'd0:    e = {14'd262, 4'd2};
      4'd1:    e = {14'd294, 4'd2};
      4'd2:    e = {14'd330, 4'd2};
      4'd3:    e = {14'd349, 4'd2};
      4'd4:    e = {14'd392, 4'd2};
      4'd5:    e = {14'd0,   4'd1};
      4'd6:    e = {14'd440, 4'd2};
      4'd7:    e = {14'd523, 4'd4};
      default: e = {14'd0,   4'd0};
    endcase
    return e;
  endfunction

  logic [1:0]        state_q,  state_d;
  logic [IDX_W-1:0]  idx_q,    idx_d;
  logic [CNT_W-1:0]  tick_q,   tick_d;
  logic [BEAT_W-1:0] beat_q,   beat_d;
  logic [CNT_W-1:0]  gap_q,    gap_d;
  logic [FREQ_W-1:0] freq_q,   freq_d;
  logic              active_q, active_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;

  logic [ENTRY_W-1:0] entry;
  logic [FREQ_W-1:0]  entry_freq;
  logic [BEAT_W-1:0]  entry_beats;

  always_comb begin
    entry       = note_entry(idx_q);
    entry_freq  = entry[ENTRY_W-1:BEAT_W];
    entry_beats = entry[BEAT_W-1:0];
  end

  // Next-state and output logic; stop overrides everything below it.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tick_d   = tick_q;
    beat_d   = beat_q;
    gap_d    = gap_q;
    freq_d   = freq_q;
    active_d = active_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (play) begin
          state_d = S_FETCH;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_FETCH: begin
        if (entry_beats == '0) begin
          if (loop_enable) begin
            idx_d = '0;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          state_d  = S_NOTE;
          freq_d   = entry_freq;
          active_d = (entry_freq != '0);
          tick_d   = '0;
          beat_d   = '0;
        end
      end
      S_NOTE: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          beat_d = BEAT_W'(beat_q + 4'd1);
          if (beat_q == BEAT_W'(entry_beats - 4'd1)) begin
            freq_d   = '0;
            active_d = 1'b0;
            if (HAS_GAP) begin
              state_d = S_GAP;
              gap_d   = '0;
            end else begin
              state_d = S_FETCH;
              idx_d   = IDX_W'(idx_q + 4'd1);
            end
          end
        end else begin
          tick_d = CNT_W'(tick_q + 16'd1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_FETCH;
          idx_d   = IDX_W'(idx_q + 4'd1);
        end else begin
          gap_d = CNT_W'(gap_q + 16'd1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (stop) begin
      state_d  = S_IDLE;
      idx_d    = '0;
      freq_d   = '0;
      active_d = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK_32KHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      tick_q   <= '0;
      beat_q   <= '0;
      gap_q    <= '0;
      freq_q   <= '0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tick_q   <= tick_d;
      beat_q   <= beat_d;
      gap_q    <= gap_d;
      freq_q   <= freq_d;
      active_q <= active_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign outputFrequency = freq_q;
  assign noteActive      = active_q;
  assign noteIndex       = idx_q;
  assign busy            = busy_q;
  assign songDone        = done_q;

endmodule

// File: tb/tb_music_note_sequencer.sv
// Bench for music_note_sequencer: fixed timing vectors, hand-written corner cases,
// and random play/stop/loop traffic against a song-position reference model.
module tb_music_note_sequencer;

  localparam int unsigned T0 = 5;
  localparam int unsigned G0 = 3;
  localparam int unsigned T1 = 1;
  localparam int unsigned G1 = 0;

  logic clk;
  logic reset_n, play, stop, loop_enable;

  logic [13:0] f0, f1;
  logic        a0, a1, b0, b1, d0, d1;
  logic [3:0]  i0, i1;
  logic [20:0] out0, out1;

  assign out0 = {f0, a0, i0, b0, d0};
  assign out1 = {f1, a1, i1, b1, d1};

  music_note_sequencer #(.TICKS_PER_BEAT(T0), .GAP_TICKS(G0)) u_dut (
    .CLK_32KHz(clk), .reset_n(reset_n), .play(play), .stop(stop),
    .loop_enable(loop_enable), .outputFrequency(f0), .noteActive(a0),
    .noteIndex(i0), .busy(b0), .songDone(d0));

  music_note_sequencer #(.TICKS_PER_BEAT(T1), .GAP_TICKS(G1)) u_dut_g0 (
    .CLK_32KHz(clk), .reset_n(reset_n), .play(play), .stop(stop),
    .loop_enable(loop_enable), .outputFrequency(f1), .noteActive(a1),
    .noteIndex(i1), .busy(b1), .songDone(d1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  int freq_tab  [16];
  int beats_tab [16];

  // Model: position p within the current entry; p==0 is the fetch cycle,
  // 1..beats*T is the sounding note, the rest up to beats*T+G is the gap.
  bit m_run  [2];
  int m_i    [2];
  int m_p    [2];
  bit m_done [2];

  typedef struct {
    int          e;
    logic [13:0] f;
    logic        a;
    logic [3:0]  i;
    logic        b;
    logic        d;
  } vec_t;

  vec_t vecs [16];

  function automatic int tpb(input int k);
    return (k == 0) ? int'(T0) : int'(T1);
  endfunction

  function automatic int gap(input int k);
    return (k == 0) ? int'(G0) : int'(G1);
  endfunction

  function automatic logic [20:0] model_out(input int k);
    logic [13:0] f;
    logic        a;
    int          note_len;
    f = '0;
    a = 1'b0;
    note_len = beats_tab[m_i[k]] * tpb(k);
    if (m_run[k] && m_p[k] >= 1 && m_p[k] <= note_len) begin
      f = 14'(freq_tab[m_i[k]]);
      a = (freq_tab[m_i[k]] != 0);
    end
    return {f, a, 4'(m_i[k]), m_run[k], m_done[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 1'b0; m_i[k] = 0; m_p[k] = 0; m_done[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 1'b0;
      if (stop) begin
        m_run[k] = 1'b0; m_i[k] = 0; m_p[k] = 0;
      end else if (!m_run[k]) begin
        if (play) begin
          m_run[k] = 1'b1; m_i[k] = 0; m_p[k] = 0;
        end
      end else if (m_p[k] == 0 && beats_tab[m_i[k]] == 0) begin
        if (loop_enable) m_i[k] = 0;
        else begin
          m_run[k] = 1'b0; m_done[k] = 1'b1;
        end
      end else begin
        m_p[k]++;
        if (m_p[k] == beats_tab[m_i[k]] * tpb(k) + gap(k) + 1) begin
          m_i[k] = (m_i[k] + 1) % 16;
          m_p[k] = 0;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got f=%0d act=%0b idx=%0d busy=%0b done=%0b, expected f=%0d act=%0b idx=%0d busy=%0b done=%0b",
               name, $time, act[20:7], act[6], act[5:2], act[1], act[0],
               exp[20:7], exp[6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // One clock edge: advance the model with the pre-edge inputs, then compare both DUTs.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model_t5g3", out0, model_out(0));
    check("model_t1g0", out1, model_out(1));
  endtask

  task automatic set_vec(input int n, input int e, input int f, input bit a,
                         input int i, input bit b, input bit d);
    vecs[n].e = e; vecs[n].f = 14'(f); vecs[n].a = a;
    vecs[n].i = 4'(i); vecs[n].b = b; vecs[n].d = d;
  endtask

  bit saw_done;

  initial begin
    n_cmp = 0;
    n_fail = 0;
    freq_tab  = '{262, 294, 330, 349, 392, 0, 440, 523, 0, 0, 0, 0, 0, 0, 0, 0};
    beats_tab = '{2, 2, 2, 2, 2, 1, 2, 4, 0, 0, 0, 0, 0, 0, 0, 0};

    // Schedule for T=5, G=3 after play sampled at E0 (entry cost 1+5*beats+3).
    set_vec(0,    0,   0, 0, 0, 1, 0);
    set_vec(1,    1, 262, 1, 0, 1, 0);
    set_vec(2,   10, 262, 1, 0, 1, 0);
    set_vec(3,   11,   0, 0, 0, 1, 0);
    set_vec(4,   13,   0, 0, 0, 1, 0);
    set_vec(5,   14,   0, 0, 1, 1, 0);
    set_vec(6,   15, 294, 1, 1, 1, 0);
    set_vec(7,   72,   0, 0, 5, 1, 0);
    set_vec(8,   78,   0, 0, 5, 1, 0);
    set_vec(9,   80, 440, 1, 6, 1, 0);
    set_vec(10,  94, 523, 1, 7, 1, 0);
    set_vec(11, 113, 523, 1, 7, 1, 0);
    set_vec(12, 114,   0, 0, 7, 1, 0);
    set_vec(13, 117,   0, 0, 8, 1, 0);
    set_vec(14, 118,   0, 0, 8, 0, 1);
    set_vec(15, 119,   0, 0, 8, 0, 0);

    reset_n = 1'b0; play = 1'b0; stop = 1'b0; loop_enable = 1'b0;
    model_reset();
    #12;
    check("reset_t5g3", out0, 21'd0);
    check("reset_t1g0", out1, 21'd0);
    reset_n = 1'b1;
    tick();

    // Non-looping song against the fixed schedule.
    play = 1'b1;
    for (int e = 0; e <= 119; e++) begin
      tick();
      if (e == 0) play = 1'b0;
      for (int v = 0; v < 16; v++)
        if (vecs[v].e == e)
          check($sformatf("vec_e%0d", e), out0,
                {vecs[v].f, vecs[v].a, vecs[v].i, vecs[v].b, vecs[v].d});
    end

    // Restart after a finished song.
    play = 1'b1;
    tick();
    play = 1'b0;
    check("restart_fetch", out0, {14'd0, 1'b0, 4'd0, 1'b1, 1'b0});
    tick();
    check("restart_262", out0, {14'd262, 1'b1, 4'd0, 1'b1, 1'b0});
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // Looping song with a play pulse while busy.
    loop_enable = 1'b1;
    saw_done = 1'b0;
    play = 1'b1;
    for (int e = 0; e <= 130; e++) begin
      tick();
      play = (e == 19);
      if (d0) saw_done = 1'b1;
      if (e == 118) check("loop_refetch", out0, {14'd0, 1'b0, 4'd0, 1'b1, 1'b0});
      if (e == 119) check("loop_262", out0, {14'd262, 1'b1, 4'd0, 1'b1, 1'b0});
    end
    check("loop_no_done", {20'd0, saw_done}, 21'd0);

    // Stop mid-note while looping.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_t5g3", out0, 21'd0);
    check("stop_t1g0", out1, 21'd0);
    loop_enable = 1'b0;

    // play and stop together from IDLE.
    play = 1'b1; stop = 1'b1;
    tick();
    play = 1'b0; stop = 1'b0;
    check("play_stop_t5g3", out0, 21'd0);
    tick();
    check("play_stop_idle", out0, 21'd0);

    // Asynchronous reset in the middle of a note.
    play = 1'b1;
    tick();
    play = 1'b0;
    for (int e = 0; e < 5; e++) tick();
    check("pre_reset_note", out0, {14'd262, 1'b1, 4'd0, 1'b1, 1'b0});
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_reset_t5g3", out0, 21'd0);
    check("async_reset_t1g0", out1, 21'd0);
    #2;
    reset_n = 1'b1;

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      play = ($urandom_range(0, 7) == 0);
      stop = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 63) == 0) loop_enable = ~loop_enable;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
